multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//   Multicycle main control FSM; drives the ALUControl input side (aluOp, funct3, funct7Parts).
//   Holds the instruction register (IR) and sequences fetch, decode, execute, memory and writeback.
//   Issues datapath strobes and a req/ready memory handshake.
//   Traps sticky on an illegal opcode or a memory timeout.
// PARAMETERS
//   TIMEOUT_CYCLES  16  max wait cycles for mem_ready in FETCH/MEM before fault
//   TIMEOUT_W       5   width of wait counter (must hold TIMEOUT_CYCLES)
// PORTS
//   clk           in   1   clock, rising edge
//   rst_n         in   1   synchronous, active-low reset
//   instr_rdata   in   32  instruction word from memory, valid when mem_ready=1 in FETCH
//   mem_ready     in   1   memory completes current request this cycle
//   branch_taken  in   1   ALU compare result (aluResult[0]), sampled in EXEC for branches
//   mem_req       out  1   memory request (FETCH, MEM)
//   mem_we        out  1   memory write (MEM, store only)
//   ir_write      out  1   IR load strobe
//   pc_write      out  1   PC update strobe
//   pc_src        out  1   0=PC+4, 1=branch target
//   alu_src_b     out  1   0=rs2, 1=immediate
//   reg_write     out  1   register-file write strobe
//   wb_sel        out  1   0=ALU result, 1=load data
//   aluOp         out  2   00 ADD(ld/st), 01 branch, 10 R-type, 11 I-type ALU
//   funct3        out  3   IR[14:12] to ALUControl
//   funct7Parts   out  2   {IR[30],IR[25]} to ALUControl (qualified below)
//   fault         out  1   sticky trap indicator
//   fault_code    out  2   00 none, 01 illegal opcode, 10 fetch timeout, 11 mem timeout
// BEHAVIOUR
//   Reset: state=FETCH, IR=0, counter=0; every output 0 except mem_req=1 (first cycle after reset is FETCH).
//   Reset mid-operation returns to FETCH on the next edge; any pending request is abandoned.
//   States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Strobes are Moore/combinational per state, one cycle wide.
//   FETCH: mem_req=1.
//     mem_ready=1: ir_write=1, IR<=instr_rdata, counter<=0, go DECODE.
//     Otherwise counter++; at counter==TIMEOUT_CYCLES-1 go TRAP with code 10.
//   DECODE (1 cycle): classify IR[6:0]; latch aluOp/funct3/funct7Parts, held until the next DECODE.
//     R 0110011: aluOp 10, funct7Parts={IR30,IR25}.
//     I-ALU 0010011: aluOp 11, funct7Parts={IR30 if funct3==101 else 0, 0}.
//     LOAD 0000011 / STORE 0100011: aluOp 00, funct7Parts=00.
//     BRANCH 1100011: aluOp 01, funct7Parts=00.
//     funct3=IR[14:12] for all legal classes. Any other opcode: TRAP, code 01.
//   EXEC: alu_src_b=1 for I-ALU/ld/st, 0 for R/branch.
//     Branch: pc_write=1, pc_src=branch_taken, go FETCH. R/I-ALU: go WB. ld/st: go MEM.
//   MEM: mem_req=1, mem_we=(store), alu_src_b=1.
//     mem_ready=1: load goes WB; store asserts pc_write=1 (pc_src=0) and goes FETCH.
//     Timeout rule as in FETCH, code 11.
//   WB: reg_write=1, wb_sel=(load), pc_write=1, pc_src=0, go FETCH.
//   TRAP: all strobes 0, mem_req=0, fault=1, fault_code held; exits only via rst_n=0.
//   mem_ready outside FETCH/MEM is ignored. Wait counter saturates; cleared on state exit.
//   Latency (mem_ready same cycle as request): R/I 4 cycles, branch 3, store 4, load 5.
// TESTING
//   1. 0x40000033 (sub), ready immediate: aluOp=10, funct3=0, funct7Parts=10;
//      reg_write in cycle 4; FETCH at cycle 5.
//   2. 0x00006013 (ori): aluOp=11, funct3=6, funct7Parts=00, alu_src_b=1 in EXEC.
//      0x40005013 (srai): funct7Parts=10.
//   3. 0x00000063 (beq), branch_taken=1: EXEC pc_write=1, pc_src=1.
//      Repeat with branch_taken=0: pc_src=0. No reg_write in either case.
//   4. 0x00002003 (lw), mem_ready delayed 3 cycles in MEM: mem_req held, mem_we=0,
//      then WB reg_write=1, wb_sel=1. Store 0x00002023: mem_we=1, no reg_write.
//   5. mem_ready low 16 cycles in FETCH -> fault=1, code 10, mem_req=0, sticky.
//      0x0000007F -> fault code 01. rst_n=0 clears both.
//   6. rst_n=0 for 1 cycle during MEM -> next cycle FETCH, mem_we=0, aluOp=00, fault=0.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle main control FSM with instruction register,
//               req/ready memory handshake and sticky trap reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_W      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_rdata,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src_b,
    output logic        reg_write,
    output logic        wb_sel,
    output logic [1:0]  aluOp,
    output logic [2:0]  funct3,
    output logic [1:0]  funct7Parts,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [TIMEOUT_W-1:0] c_cnt_last = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_code_illegal = 2'b01;
    localparam logic [1:0] c_code_fetch   = 2'b10;
    localparam logic [1:0] c_code_mem     = 2'b11;

    typedef enum logic [2:0] {
        s_fetch  = 3'd0,
        s_decode = 3'd1,
        s_exec   = 3'd2,
        s_mem    = 3'd3,
        s_wb     = 3'd4,
        s_trap   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        cls_r  = 3'd0,
        cls_i  = 3'd1,
        cls_ld = 3'd2,
        cls_st = 3'd3,
        cls_br = 3'd4
    } cls_t;

    state_t                 r_state;
    state_t                 w_next_state;
    cls_t                   r_cls;
    cls_t                   w_dec_cls;
    logic [31:0]            r_ir;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic [TIMEOUT_W-1:0]   w_cnt_next;
    logic [1:0]             r_alu_op;
    logic [2:0]             r_funct3;
    logic [1:0]             r_funct7;
    logic [1:0]             r_fault_code;
    logic [1:0]             w_fault_code_next;
    logic [1:0]             w_dec_alu_op;
    logic [1:0]             w_dec_funct7;
    logic                   w_dec_legal;
    logic                   w_waiting;
    logic                   w_timeout;
    logic                   w_unused;

    // Only opcode/funct fields feed control; the rest of IR is for the datapath.
    assign w_unused = ^r_ir;

    // Opcode classification of the currently held instruction.
    always_comb begin
        w_dec_legal  = 1'b1;
        w_dec_cls    = cls_r;
        w_dec_alu_op = 2'b00;
        w_dec_funct7 = 2'b00;
        unique case (r_ir[6:0])
            c_op_r: begin
                w_dec_cls    = cls_r;
                w_dec_alu_op = 2'b10;
                w_dec_funct7 = {r_ir[30], r_ir[25]};
            end
            c_op_i: begin
                w_dec_cls    = cls_i;
                w_dec_alu_op = 2'b11;
                w_dec_funct7 = {(r_ir[14:12] == 3'b101) ? r_ir[30] : 1'b0, 1'b0};
            end
            c_op_load: begin
                w_dec_cls    = cls_ld;
                w_dec_alu_op = 2'b00;
            end
            c_op_store: begin
                w_dec_cls    = cls_st;
                w_dec_alu_op = 2'b00;
            end
            c_op_branch: begin
                w_dec_cls    = cls_br;
                w_dec_alu_op = 2'b01;
            end
            default: w_dec_legal = 1'b0;
        endcase
    end

    assign w_waiting = ((r_state == s_fetch) || (r_state == s_mem)) && !mem_ready;
    assign w_timeout = w_waiting && (r_cnt == c_cnt_last);

    // Next state and Moore/handshake strobes.
    always_comb begin
        w_next_state      = r_state;
        w_fault_code_next = r_fault_code;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        ir_write          = 1'b0;
        pc_write          = 1'b0;
        pc_src            = 1'b0;
        alu_src_b         = 1'b0;
        reg_write         = 1'b0;
        wb_sel            = 1'b0;
        unique case (r_state)
            s_fetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    w_next_state = s_decode;
                end else if (w_timeout) begin
                    w_next_state      = s_trap;
                    w_fault_code_next = c_code_fetch;
                end
            end
            s_decode: begin
                if (w_dec_legal) begin
                    w_next_state = s_exec;
                end else begin
                    w_next_state      = s_trap;
                    w_fault_code_next = c_code_illegal;
                end
            end
            s_exec: begin
                alu_src_b = (r_cls == cls_i) || (r_cls == cls_ld) || (r_cls == cls_st);
                unique case (r_cls)
                    cls_br: begin
                        pc_write     = 1'b1;
                        pc_src       = branch_taken;
                        w_next_state = s_fetch;
                    end
                    cls_ld, cls_st: w_next_state = s_mem;
                    default:        w_next_state = s_wb;
                endcase
            end
            s_mem: begin
                mem_req   = 1'b1;
                mem_we    = (r_cls == cls_st);
                alu_src_b = 1'b1;
                if (mem_ready) begin
                    if (r_cls == cls_st) begin
                        pc_write     = 1'b1;
                        w_next_state = s_fetch;
                    end else begin
                        w_next_state = s_wb;
                    end
                end else if (w_timeout) begin
                    w_next_state      = s_trap;
                    w_fault_code_next = c_code_mem;
                end
            end
            s_wb: begin
                reg_write    = 1'b1;
                wb_sel       = (r_cls == cls_ld);
                pc_write     = 1'b1;
                w_next_state = s_fetch;
            end
            s_trap: w_next_state = s_trap;
            default: w_next_state = s_fetch;
        endcase
    end

    // Wait counter: cleared whenever the state changes, saturates otherwise.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next_state != r_state) begin
            w_cnt_next = '0;
        end else if (w_waiting && (r_cnt != c_cnt_last)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= s_fetch;
            r_ir         <= '0;
            r_cnt        <= '0;
            r_cls        <= cls_r;
            r_alu_op     <= 2'b00;
            r_funct3     <= 3'b000;
            r_funct7     <= 2'b00;
            r_fault_code <= 2'b00;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_cnt_next;
            r_fault_code <= w_fault_code_next;
            if (ir_write) begin
                r_ir <= instr_rdata;
            end
            if ((r_state == s_decode) && w_dec_legal) begin
                r_cls    <= w_dec_cls;
                r_alu_op <= w_dec_alu_op;
                r_funct3 <= r_ir[14:12];
                r_funct7 <= w_dec_funct7;
            end
        end
    end

    assign aluOp       = r_alu_op;
    assign funct3      = r_funct3;
    assign funct7Parts = r_funct7;
    assign fault       = (r_state == s_trap);
    assign fault_code  = r_fault_code;

endmodule
`default_nettype wire
